// File: rtl/pe_seq_pkg.sv
// rtl/pe_seq_pkg.sv - shared types, constants and helpers for the PE array sequencer
// Defines the build-time sizes N_PE (lane count) and ADDR_FIFO (map dimension
// width) when the build does not supply them, the sequencer state encoding,
// the drain latency, the kernel-size clamp and the lane mask helper.
`ifndef N_PE
`define N_PE 4
`endif
`ifndef ADDR_FIFO
`define ADDR_FIFO 10
`endif

package pe_seq_pkg;

  localparam int N_PE      = `N_PE;
  localparam int ADDR_W    = `ADDR_FIFO;
  // Pixel/word counter width: holds K*K + row_length*num_rows without overflow.
  localparam int WORD_W    = 2*ADDR_W + 6;
  localparam int DRAIN_LAT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_FLT,
    S_FILL,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  // Out-of-range kernel sizes (0 or wider than the array) run as K = 1.
  function automatic logic [2:0] k_clamp(input logic [2:0] fs);
    if (fs == 3'd0 || int'(fs) > N_PE) begin
      return 3'd1;
    end
    return fs;
  endfunction

  // Lanes 0..K-1 set.
  function automatic logic [N_PE-1:0] lane_mask(input logic [2:0] k);
    logic [N_PE-1:0] m;
    m = '0;
    for (int i = 0; i < N_PE; i++) begin
      if (i < int'(k)) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/pe_seq_counter.sv
// rtl/pe_seq_counter.sv - loadable counter with enable, optional wrap and terminal-count flag
// Ports: clk, rst_n (async active-low), i_load/i_load_val (load has priority),
// i_en (count enable), i_wrap (wrap to 0 after i_max), i_max (terminal value),
// o_count (current value), o_tc (o_count == i_max).
module pe_seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_wrap,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  assign o_count = r_count;
  assign o_tc    = (r_count == i_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= (i_wrap && o_tc) ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/pe_array_sequencer.sv
// rtl/pe_array_sequencer.sv - layer sequencer driving the per-lane controls of a K-wide PE array
// Inputs: clk, rst_n (async active-low), start, abort, row_length, num_rows,
// filter_size, nl_type_cfg, last_bank, in_valid.
// Outputs: in_ready, busy, done, per-lane shifting_filter/shifting_line/
// mac_enable/adder_enable/nl_enable/feedback_enable, line_buffer_reset,
// final_filter_bank, nl_type.
// Optional build macro PE_SEQ_POOL_EN adds pool_enable, pool_nl inputs and
// shifting_line_pool, line_buffer_reset_pool, row_length_pool outputs.
module pe_array_sequencer
  import pe_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] row_length,
  input  logic [ADDR_W-1:0] num_rows,
  input  logic [2:0]        filter_size,
  input  logic [2:0]        nl_type_cfg,
  input  logic              last_bank,
  input  logic              in_valid,
`ifdef PE_SEQ_POOL_EN
  input  logic              pool_enable,
  input  logic [2:0]        pool_nl,
  output logic              shifting_line_pool,
  output logic              line_buffer_reset_pool,
  output logic [ADDR_W-1:0] row_length_pool,
`endif
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [N_PE-1:0]   shifting_filter,
  output logic [N_PE-1:0]   shifting_line,
  output logic [N_PE-1:0]   mac_enable,
  output logic [N_PE-1:0]   adder_enable,
  output logic [N_PE-1:0]   nl_enable,
  output logic [N_PE-1:0]   feedback_enable,
  output logic              line_buffer_reset,
  output logic              final_filter_bank,
  output logic [2:0]        nl_type
);

  seq_state_t        r_state;
  seq_state_t        w_next;
  logic [2:0]        r_k;
  logic [ADDR_W-1:0] r_rl;
  logic [ADDR_W-1:0] r_nr;
  logic [2:0]        r_nl_type;
  logic              r_last_bank;
  logic              r_lb_reset;
  logic [1:0]        r_drain;

  logic              w_accept;
  logic              w_idle;
  logic              w_pix_phase;
  logic              w_drain_last;
  logic [2:0]        w_km1;
  logic [N_PE-1:0]   w_mask;
  logic [WORD_W-1:0] w_kk;
  logic [WORD_W-1:0] w_fill_len;
  logic [WORD_W-1:0] w_total;
  logic [WORD_W-1:0] w_word_max;
  logic [WORD_W-1:0] w_word_cnt;
  logic              w_word_tc;
  logic [ADDR_W-1:0] w_col;
  logic              w_col_tc;
  logic [ADDR_W-1:0] w_row;
  logic              w_row_tc;

  assign w_idle       = (r_state == S_IDLE);
  assign w_pix_phase  = (r_state == S_FILL) || (r_state == S_COMPUTE);
  assign w_accept     = in_valid && in_ready;
  assign w_drain_last = (r_state == S_DRAIN) && (r_drain == 2'(DRAIN_LAT - 1));
  assign w_km1        = r_k - 3'd1;
  assign w_mask       = lane_mask(r_k);

  assign w_kk       = WORD_W'(r_k) * WORD_W'(r_k);
  assign w_fill_len = WORD_W'(w_km1) * WORD_W'(r_rl) + WORD_W'(w_km1);
  assign w_total    = w_kk + WORD_W'(r_rl) * WORD_W'(r_nr);

  // The word counter runs across the whole layer; its terminal value moves
  // with the phase so one flag marks the end of filter load and of fill.
  always_comb begin
    w_word_max = w_kk - WORD_W'(1);
    if (r_state == S_FILL) begin
      w_word_max = w_kk + w_fill_len - WORD_W'(1);
    end
  end

  pe_seq_counter #(.W(WORD_W)) u_word_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_idle),
    .i_load_val ('0),
    .i_en       (w_accept),
    .i_wrap     (1'b0),
    .i_max      (w_word_max),
    .o_count    (w_word_cnt),
    .o_tc       (w_word_tc)
  );

  // Column/row track the raster position of every pixel, fill included, so
  // COMPUTE starts at column K-1 of row K-1.
  pe_seq_counter #(.W(ADDR_W)) u_col_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_idle),
    .i_load_val ('0),
    .i_en       (w_accept && w_pix_phase),
    .i_wrap     (1'b1),
    .i_max      (r_rl - ADDR_W'(1)),
    .o_count    (w_col),
    .o_tc       (w_col_tc)
  );

  pe_seq_counter #(.W(ADDR_W)) u_row_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_idle),
    .i_load_val ('0),
    .i_en       (w_accept && w_pix_phase && w_col_tc),
    .i_wrap     (1'b1),
    .i_max      (r_nr - ADDR_W'(1)),
    .o_count    (w_row),
    .o_tc       (w_row_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_rl        <= '0;
      r_nr        <= '0;
      r_nl_type   <= '0;
      r_last_bank <= 1'b0;
      r_lb_reset  <= 1'b0;
      r_drain     <= '0;
    end else begin
      r_state    <= w_next;
      r_lb_reset <= w_idle && start && !abort;
      if (w_idle && start) begin
        r_k         <= k_clamp(filter_size);
        r_rl        <= row_length;
        r_nr        <= num_rows;
        r_nl_type   <= nl_type_cfg;
        r_last_bank <= last_bank;
      end
      if (r_state == S_DRAIN && !abort) begin
        r_drain <= r_drain + 2'd1;
      end else begin
        r_drain <= '0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD_FLT;
      end
      S_LOAD_FLT: begin
        if (w_accept && w_word_tc) begin
          if (r_rl == '0 || r_nr == '0) begin
            w_next = S_DRAIN;
          end else if (w_fill_len == '0) begin
            w_next = S_COMPUTE;
          end else begin
            w_next = S_FILL;
          end
        end
      end
      S_FILL: begin
        // A map shorter than K rows runs out of pixels before fill completes.
        if (w_accept) begin
          if (w_col_tc && w_row_tc) begin
            w_next = S_DRAIN;
          end else if (w_word_tc) begin
            w_next = S_COMPUTE;
          end
        end
      end
      S_COMPUTE: begin
        if (w_accept && (w_word_cnt == w_total - WORD_W'(1))) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drain_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_comb begin
    in_ready          = 1'b0;
    shifting_filter   = '0;
    shifting_line     = '0;
    mac_enable        = '0;
    adder_enable      = '0;
    nl_enable         = '0;
    feedback_enable   = '0;
    busy              = !w_idle;
    done              = (r_state == S_DONE);
    line_buffer_reset = r_lb_reset;
    final_filter_bank = !w_idle && r_last_bank;
    nl_type           = w_idle ? 3'd0 : r_nl_type;

    if (r_state == S_LOAD_FLT || w_pix_phase) begin
      in_ready = 1'b1;
    end
    if (r_state == S_LOAD_FLT && w_accept) begin
      shifting_filter = w_mask;
    end
    if (w_pix_phase && w_accept) begin
      shifting_line = w_mask;
      if (r_state == S_COMPUTE && w_col >= ADDR_W'(w_km1) && w_row >= ADDR_W'(w_km1)) begin
        mac_enable = w_mask;
      end
    end
    if (r_state == S_DRAIN) begin
      adder_enable = w_mask;
    end
    if (w_drain_last) begin
      nl_enable = w_mask;
    end
    if (!w_idle && !r_last_bank) begin
      feedback_enable = w_mask;
    end
  end

`ifdef PE_SEQ_POOL_EN
  logic r_pool_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pool_en <= 1'b0;
    end else if (w_idle && start) begin
      r_pool_en <= pool_enable;
    end
  end

  // pool_nl selects the pooling stage's own non-linearity downstream; the
  // sequencer only times the pooled line shift.
  assign shifting_line_pool     = r_pool_en && w_drain_last;
  assign line_buffer_reset_pool = r_lb_reset;
  assign row_length_pool        = w_idle ? '0 : (r_rl >> 1);
`endif

endmodule

// File: tb/tb_pe_array_sequencer.sv
// tb/tb_pe_array_sequencer.sv - directed self-checking bench for pe_array_sequencer
module tb_pe_array_sequencer;
  import pe_seq_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] row_length;
  logic [ADDR_W-1:0] num_rows;
  logic [2:0]        filter_size;
  logic [2:0]        nl_type_cfg;
  logic              last_bank;
  logic              in_valid;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [N_PE-1:0]   shifting_filter;
  logic [N_PE-1:0]   shifting_line;
  logic [N_PE-1:0]   mac_enable;
  logic [N_PE-1:0]   adder_enable;
  logic [N_PE-1:0]   nl_enable;
  logic [N_PE-1:0]   feedback_enable;
  logic              line_buffer_reset;
  logic              final_filter_bank;
  logic [2:0]        nl_type;
`ifdef PE_SEQ_POOL_EN
  logic              pool_enable;
  logic [2:0]        pool_nl;
  logic              shifting_line_pool;
  logic              line_buffer_reset_pool;
  logic [ADDR_W-1:0] row_length_pool;
`endif

  always #5 clk = ~clk;

  pe_array_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .abort             (abort),
    .row_length        (row_length),
    .num_rows          (num_rows),
    .filter_size       (filter_size),
    .nl_type_cfg       (nl_type_cfg),
    .last_bank         (last_bank),
    .in_valid          (in_valid),
`ifdef PE_SEQ_POOL_EN
    .pool_enable            (pool_enable),
    .pool_nl                (pool_nl),
    .shifting_line_pool     (shifting_line_pool),
    .line_buffer_reset_pool (line_buffer_reset_pool),
    .row_length_pool        (row_length_pool),
`endif
    .in_ready          (in_ready),
    .busy              (busy),
    .done              (done),
    .shifting_filter   (shifting_filter),
    .shifting_line     (shifting_line),
    .mac_enable        (mac_enable),
    .adder_enable      (adder_enable),
    .nl_enable         (nl_enable),
    .feedback_enable   (feedback_enable),
    .line_buffer_reset (line_buffer_reset),
    .final_filter_bank (final_filter_bank),
    .nl_type           (nl_type)
  );

  logic [63:0] w_outs;
  assign w_outs = 64'({in_ready, busy, done, shifting_filter, shifting_line, mac_enable,
                       adder_enable, nl_enable, feedback_enable, line_buffer_reset,
                       final_filter_bank, nl_type});

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int          r_flt, r_line, r_mac_n, r_adder, r_nl, r_lbr, r_slp, r_done_cyc;
  logic [63:0] r_mac_map;
  logic [63:0] r_after_abort;
  logic [63:0] r_rlp;
  bit          r_stall_bad, r_fb_bad, r_sf_bad;

  // Starts a layer and monitors it cycle by cycle until done or the budget ends.
  task automatic run_layer(input logic [2:0] fs, input int rl, input int nr, input bit lb,
                           input bit toggle, input logic [N_PE-1:0] exp_mask,
                           input int abort_at, input int limit);
    r_flt = 0; r_line = 0; r_mac_n = 0; r_adder = 0; r_nl = 0; r_lbr = 0; r_slp = 0;
    r_done_cyc = -1; r_mac_map = '0; r_after_abort = '1; r_rlp = '1;
    r_stall_bad = 0; r_fb_bad = 0; r_sf_bad = 0;
    filter_size = fs; row_length = ADDR_W'(rl); num_rows = ADDR_W'(nr);
    last_bank = lb; nl_type_cfg = 3'd5; in_valid = 1'b0; abort = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      tick();
      start = 1'b0;
      in_valid = toggle ? (cyc % 2 == 1) : 1'b1;
      abort = (cyc == abort_at);
      #1;
      if (cyc == abort_at + 1) r_after_abort = w_outs;
      if (shifting_filter != '0) begin
        r_flt++;
        if (shifting_filter !== exp_mask) r_sf_bad = 1;
      end
      if (shifting_line != '0) begin
        if (mac_enable != '0) begin
          r_mac_map[r_line] = 1'b1;
          r_mac_n++;
        end
        r_line++;
      end
      if (adder_enable != '0) r_adder++;
      if (nl_enable != '0) r_nl++;
      if (line_buffer_reset) r_lbr++;
      if (!in_valid && in_ready && (shifting_filter | shifting_line | mac_enable) != '0)
        r_stall_bad = 1;
      if (busy && (feedback_enable !== (lb ? '0 : exp_mask) || final_filter_bank !== lb
                   || nl_type !== 3'd5))
        r_fb_bad = 1;
`ifdef PE_SEQ_POOL_EN
      if (shifting_line_pool) r_slp++;
      if (busy) r_rlp = 64'(row_length_pool);
`endif
      if (done) begin
        r_done_cyc = cyc;
        break;
      end
    end
    abort = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; last_bank = 1'b0;
    row_length = '0; num_rows = '0; filter_size = '0; nl_type_cfg = '0;
`ifdef PE_SEQ_POOL_EN
    pool_enable = 1'b0; pool_nl = 3'd2;
`endif
    #1;
    check_val("reset_outputs", w_outs, 64'd0);
    start = 1'b1; in_valid = 1'b1;
    tick(); tick();
    check_val("reset_held_outputs", w_outs, 64'd0);
    start = 1'b0; in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // 4x4 map, K=3, continuous data
    run_layer(3'd3, 4, 4, 1'b0, 1'b0, 4'b0111, 0, 200);
    check_val("k3_filter_shifts", r_flt, 9);
    check_val("k3_line_shifts", r_line, 16);
    check_val("k3_mac_map", r_mac_map, 64'hCC00);
    check_val("k3_mac_count", r_mac_n, 4);
    check_val("k3_done_cycle", r_done_cyc, 29);
    check_val("k3_adder_cycles", r_adder, 3);
    check_val("k3_nl_pulses", r_nl, 1);
    check_val("k3_lb_reset_pulses", r_lbr, 1);
    check_val("k3_filter_mask", r_sf_bad, 0);
    check_val("k3_feedback_held", r_fb_bad, 0);
    tick();
    check_val("k3_idle_after_done", w_outs, 64'd0);

    // same layer with in_valid toggling 1/0
    run_layer(3'd3, 4, 4, 1'b0, 1'b1, 4'b0111, 0, 200);
    check_val("tog_filter_shifts", r_flt, 9);
    check_val("tog_mac_map", r_mac_map, 64'hCC00);
    check_val("tog_done_cycle", r_done_cyc, 53);
    check_val("tog_stall_quiet", r_stall_bad, 0);
    check_val("tog_adder_cycles", r_adder, 3);
    tick();

    // illegal filter sizes clamp to K=1; last bank set
    run_layer(3'd0, 4, 4, 1'b1, 1'b0, 4'b0001, 0, 200);
    check_val("k0_filter_shifts", r_flt, 1);
    check_val("k0_mac_map", r_mac_map, 64'hFFFF);
    check_val("k0_done_cycle", r_done_cyc, 21);
    check_val("k0_last_bank_outputs", r_fb_bad, 0);
    check_val("k0_filter_mask", r_sf_bad, 0);
    tick();
    run_layer(3'd7, 4, 4, 1'b0, 1'b0, 4'b0001, 0, 200);
    check_val("k7_filter_shifts", r_flt, 1);
    check_val("k7_mac_map", r_mac_map, 64'hFFFF);
    check_val("k7_done_cycle", r_done_cyc, 21);
    tick();

    // K=2 on a 3x2 map
    run_layer(3'd2, 3, 2, 1'b0, 1'b0, 4'b0011, 0, 200);
    check_val("k2_line_shifts", r_line, 6);
    check_val("k2_mac_map", r_mac_map, 64'h30);
    check_val("k2_done_cycle", r_done_cyc, 14);
    tick();

    // fewer rows than K: pixels run out during fill
    run_layer(3'd3, 4, 1, 1'b0, 1'b0, 4'b0111, 0, 200);
    check_val("short_line_shifts", r_line, 4);
    check_val("short_mac_map", r_mac_map, 64'h0);
    check_val("short_done_cycle", r_done_cyc, 17);
    tick();

    // zero row_length: straight from filter load to drain
    run_layer(3'd2, 0, 4, 1'b0, 1'b0, 4'b0011, 0, 200);
    check_val("rl0_filter_shifts", r_flt, 4);
    check_val("rl0_line_shifts", r_line, 0);
    check_val("rl0_done_cycle", r_done_cyc, 8);
    check_val("rl0_adder_cycles", r_adder, 3);
    tick();

    // abort mid-COMPUTE, then a fresh start
    run_layer(3'd3, 4, 4, 1'b0, 1'b0, 4'b0111, 22, 60);
    check_val("abort_outputs_next", r_after_abort, 64'd0);
    check_val("abort_no_done", r_done_cyc, -1);
    tick();
    run_layer(3'd3, 4, 4, 1'b0, 1'b0, 4'b0111, 0, 200);
    check_val("after_abort_done_cycle", r_done_cyc, 29);
    tick();

    // abort wins over start in the same cycle
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    #1;
    check_val("abort_beats_start", busy, 1'b0);
    tick();

    // asynchronous reset mid-FILL
    filter_size = 3'd3; row_length = 4; num_rows = 4; last_bank = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1;
    repeat (11) tick();
    check_val("fill_busy_before_reset", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_val("async_reset_outputs", w_outs, 64'd0);
    tick(); tick();
    check_val("reset_hold_outputs", w_outs, 64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    run_layer(3'd2, 3, 2, 1'b0, 1'b0, 4'b0011, 0, 200);
    check_val("after_reset_done_cycle", r_done_cyc, 14);
    tick();

`ifdef PE_SEQ_POOL_EN
    pool_enable = 1'b1;
    run_layer(3'd2, 8, 2, 1'b0, 1'b0, 4'b0011, 0, 200);
    check_val("pool_row_length", r_rlp, 64'd4);
    check_val("pool_nl_pulses", r_nl, 1);
    check_val("pool_shift_pulses", r_slp, 1);
    pool_enable = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
